input_debounce: RTL and testbench



---
 rtl/db_pkg.sv | 25 ++
 rtl/db_channel.sv | 99 +++++++++
 rtl/input_debounce.sv | 30 +++
 tb/tb_input_debounce.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared definitions for the input debouncer: FSM state encoding and the
// counter-width helper used to size each channel's stability counter.
package db_pkg;

    typedef enum logic [1:0] {
        S_ZERO  = 2'b00,
        S_WAIT1 = 2'b01,
        S_ONE   = 2'b11,
        S_WAIT0 = 2'b10
    } db_state_e;

    // Bits needed to hold the values 0..v-1; never less than one bit.
    function automatic int clog2(input int unsigned v);
        int          w;
        int unsigned m;
        w = 0;
        m = 1;
        while (m < v) begin
            m = m << 1;
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounced input: optional inversion, 2-flop synchronizer, stability
// FSM with qualification counter, and registered level/edge-tick outputs.
module db_channel
    import db_pkg::*;
#(
    parameter int unsigned DB_TICKS = 1_000_000,
    parameter bit          INV      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);

    localparam int            CW   = clog2(DB_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic [1:0]    r_sync;
    logic          w_s;
    db_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the synchronizer stages shift correctly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], raw_in ^ INV};
        end
    end

    assign w_s = r_sync[1];

    // Level and ticks update on the same edge as the state change, so the
    // tick coincides with the first cycle of the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_ZERO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                S_ZERO: begin
                    if (w_s) begin
                        r_state <= S_WAIT1;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT1: begin
                    if (!w_s) begin
                        r_state <= S_ZERO;
                    end else if (r_cnt == LAST) begin
                        r_state <= S_ONE;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ONE: begin
                    if (!w_s) begin
                        r_state <= S_WAIT0;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT0: begin
                    if (w_s) begin
                        r_state <= S_ONE;
                    end else if (r_cnt == LAST) begin
                        r_state <= S_ZERO;
                        r_level <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_ZERO;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign db_level = r_level;
    assign db_rise  = r_rise;
    assign db_fall  = r_fall;

endmodule

// File: rtl/input_debounce.sv
// N independent debounced inputs for buttons and switches; each channel
// yields a clean level plus one-cycle rise/fall ticks.
module input_debounce #(
    parameter int unsigned N        = 10,
    parameter int unsigned DB_TICKS = 1_000_000,
    parameter logic [N-1:0] INV_MASK = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] db_level,
    output logic [N-1:0] db_rise,
    output logic [N-1:0] db_fall
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        db_channel #(
            .DB_TICKS (DB_TICKS),
            .INV      (INV_MASK[i])
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .raw_in   (raw_in[i]),
            .db_level (db_level[i]),
            .db_rise  (db_rise[i]),
            .db_fall  (db_fall[i])
        );
    end

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce at DB_TICKS=4: expectations are queued
// per cycle as stimulus is applied and compared on the falling clock edge.
module tb_input_debounce;

    localparam int N  = 10;
    localparam int DB = 4;

    typedef struct {
        int         cyc;
        bit         inv;
        string      tag;
        logic [9:0] lvl;
        logic [9:0] rise;
        logic [9:0] fall;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic [9:0] raw;
    logic [9:0] raw_i;
    logic [9:0] lvl, rise, fall;
    logic [9:0] lvl_i, rise_i, fall_i;
    logic [9:0] ol, orise, ofall;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    input_debounce #(.N(N), .DB_TICKS(DB), .INV_MASK(10'h000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_in   (raw),
        .db_level (lvl),
        .db_rise  (rise),
        .db_fall  (fall)
    );

    input_debounce #(.N(N), .DB_TICKS(DB), .INV_MASK(10'h003)) dut_inv (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw_in   (raw_i),
        .db_level (lvl_i),
        .db_rise  (rise_i),
        .db_fall  (fall_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit inv, input string tag,
                        input logic [9:0] l, input logic [9:0] r, input logic [9:0] f);
        exp_t e;
        e.cyc  = c;
        e.inv  = inv;
        e.tag  = tag;
        e.lvl  = l;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                ol    = sb[i].inv ? lvl_i  : lvl;
                orise = sb[i].inv ? rise_i : rise;
                ofall = sb[i].inv ? fall_i : fall;
                checks++;
                assert (ol === sb[i].lvl) else begin
                    errors++;
                    $error("FAIL %s level @%0d: got %h expected %h", sb[i].tag, cyc, ol, sb[i].lvl);
                end
                checks++;
                assert (orise === sb[i].rise) else begin
                    errors++;
                    $error("FAIL %s rise @%0d: got %h expected %h", sb[i].tag, cyc, orise, sb[i].rise);
                end
                checks++;
                assert (ofall === sb[i].fall) else begin
                    errors++;
                    $error("FAIL %s fall @%0d: got %h expected %h", sb[i].tag, cyc, ofall, sb[i].fall);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $error("FAIL %s missed @%0d: now %0d", sb[i].tag, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        int e, f, g, h, r, t;

        // Reset held with all raw inputs high: everything stays 0.
        reset_n = 1'b0;
        raw     = 10'h3FF;
        raw_i   = 10'h000;
        at_edge();
        e = cyc;
        for (int k = 1; k <= 2; k++) begin
            push(e + k, 1'b0, "in_reset", 10'h000, 10'h000, 10'h000);
            push(e + k, 1'b1, "in_reset_inv", 10'h000, 10'h000, 10'h000);
        end
        repeat (3) at_edge();

        // Release: all channels qualify high at release+7, inverted ones too.
        reset_n = 1'b1;
        e = cyc;
        for (int k = 1; k <= 6; k++) begin
            push(e + k, 1'b0, "rel_wait", 10'h000, 10'h000, 10'h000);
            push(e + k, 1'b1, "inv_wait", 10'h000, 10'h000, 10'h000);
        end
        push(e + 7, 1'b0, "rel_rise", 10'h3FF, 10'h3FF, 10'h000);
        push(e + 7, 1'b1, "inv_rise", 10'h003, 10'h003, 10'h000);
        push(e + 8, 1'b0, "rel_hold", 10'h3FF, 10'h000, 10'h000);
        push(e + 8, 1'b1, "inv_hold", 10'h003, 10'h000, 10'h000);
        repeat (9) at_edge();

        // All inputs drop together: simultaneous fall ticks.
        raw = 10'h000;
        e = cyc;
        push(e + 6, 1'b0, "fall_wait", 10'h3FF, 10'h000, 10'h000);
        push(e + 7, 1'b0, "fall_all", 10'h000, 10'h000, 10'h3FF);
        push(e + 8, 1'b0, "fall_hold", 10'h000, 10'h000, 10'h000);
        repeat (9) at_edge();

        // Clean rising edge on channel 0.
        raw[0] = 1'b1;
        e = cyc;
        push(e + 6, 1'b0, "clean_wait", 10'h000, 10'h000, 10'h000);
        push(e + 7, 1'b0, "clean_rise", 10'h001, 10'h001, 10'h000);
        push(e + 8, 1'b0, "clean_hold", 10'h001, 10'h000, 10'h000);
        repeat (9) at_edge();

        // Bounce on channel 1: 2-cycle phases are rejected, final high accepted.
        e = cyc;
        for (int k = 1; k <= 14; k++)
            push(e + k, 1'b0, "bounce_hold", 10'h001, 10'h000, 10'h000);
        push(e + 15, 1'b0, "bounce_rise", 10'h003, 10'h002, 10'h000);
        push(e + 16, 1'b0, "bounce_after", 10'h003, 10'h000, 10'h000);
        raw[1] = 1'b1; repeat (2) at_edge();
        raw[1] = 1'b0; repeat (2) at_edge();
        raw[1] = 1'b1; repeat (2) at_edge();
        raw[1] = 1'b0; repeat (2) at_edge();
        raw[1] = 1'b1;
        f = cyc;
        repeat (9) at_edge();

        // 3-cycle glitch on channel 5 must be filtered.
        g = cyc;
        for (int k = 1; k <= 12; k++)
            push(g + k, 1'b0, "glitch", 10'h003, 10'h000, 10'h000);
        raw[5] = 1'b1;
        repeat (3) at_edge();
        raw[5] = 1'b0;
        repeat (10) at_edge();

        // Channel 3 rises; reset hits two cycles into its WAIT1 state.
        h = cyc;
        for (int k = 1; k <= 4; k++)
            push(h + k, 1'b0, "mid_pre", 10'h003, 10'h000, 10'h000);
        raw[3] = 1'b1;
        repeat (5) at_edge();
        reset_n = 1'b0;
        for (int k = 0; k <= 1; k++) begin
            push(h + 5 + k, 1'b0, "mid_reset", 10'h000, 10'h000, 10'h000);
            push(h + 5 + k, 1'b1, "mid_reset_inv", 10'h000, 10'h000, 10'h000);
        end
        repeat (2) at_edge();
        reset_n = 1'b1;
        r = cyc;
        for (int k = 1; k <= 6; k++)
            push(r + k, 1'b0, "requal_wait", 10'h000, 10'h000, 10'h000);
        push(r + 6, 1'b1, "requal_wait_inv", 10'h000, 10'h000, 10'h000);
        push(r + 7, 1'b0, "requal_rise", 10'h00B, 10'h00B, 10'h000);
        push(r + 7, 1'b1, "requal_rise_inv", 10'h003, 10'h003, 10'h000);
        push(r + 8, 1'b0, "requal_hold", 10'h00B, 10'h000, 10'h000);
        repeat (10) at_edge();

        t = 0;
        while (sb.size() > 0 && t < 50) begin
            at_edge();
            t++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: %0d expectations still pending, expected 0 (bounce end %0d)", sb.size(), f);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
